// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable synthetic test image (colour bars, ramp, checker, flat gray).
// All outputs are registered one cycle behind the free-running h/v counters.
module video_pattern_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        pixelclk,
   input  logic        reset_n,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   output logic [23:0] o_rgb,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_sof
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int SW      = $clog2(BAR_W);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_FLAT  = 2'd3
   } pattern_e;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [2:0]    idx_q, idx_d;
   logic [SW-1:0] sub_q, sub_d;
   pattern_e      pat_q, pat_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic          sof_q, sof_d;
   logic          origin;
   pattern_e      pat_use;
   logic          chk_bit;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   always_comb begin
      h_d     = '0;
      v_d     = '0;
      idx_d   = '0;
      sub_d   = '0;
      pat_d   = pat_q;
      rgb_d   = '0;
      hs_d    = ~SYNC_POL;
      vs_d    = ~SYNC_POL;
      de_d    = 1'b0;
      sof_d   = 1'b0;
      origin  = (h_q == '0) && (v_q == '0);
      pat_use = origin ? pattern_e'(i_pattern) : pat_q;
      chk_bit = 1'((32'(h_q) ^ 32'(v_q)) >> 5);

      if (i_en) begin
         pat_d = pat_use;
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
         end else begin
            h_d = h_q + HW'(1);
            v_d = v_q;
         end

         // Bar state tracks h_d so it is aligned with h_q on the next cycle
         if (h_d != '0) begin
            if (sub_q == SUB_LAST) begin
               sub_d = '0;
               idx_d = idx_q + 3'd1;
            end else begin
               sub_d = sub_q + SW'(1);
               idx_d = idx_q;
            end
         end

         de_d  = (h_q < H_ACT) && (v_q < V_ACT);
         hs_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vs_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
         sof_d = origin;

         if (de_d) begin
            case (pat_use)
               PAT_BARS:  rgb_d = bar_colour(idx_q);
               PAT_RAMP:  rgb_d = {3{8'(h_q)}};
               PAT_CHECK: rgb_d = chk_bit ? 24'hFFFFFF : 24'h000000;
               default:   rgb_d = 24'h808080;
            endcase
         end
      end
   end

   always_ff @(posedge pixelclk) begin
      if (!reset_n) begin
         h_q   <= '0;
         v_q   <= '0;
         idx_q <= '0;
         sub_q <= '0;
         pat_q <= PAT_BARS;
         rgb_q <= '0;
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
         de_q  <= 1'b0;
         sof_q <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         idx_q <= idx_d;
         sub_q <= sub_d;
         pat_q <= pat_d;
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
         sof_q <= sof_d;
      end
   end

   assign o_rgb   = rgb_q;
   assign o_hsync = hs_q;
   assign o_vsync = vs_q;
   assign o_de    = de_q;
   assign o_sof   = sof_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: frame-position reference model plus directed timing checks.
module tb_video_pattern_gen;

   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;

   logic        pixelclk = 1'b0;
   logic        reset_n  = 1'b0;
   logic        i_en     = 1'b0;
   logic [1:0]  i_pattern = 2'd0;
   logic [23:0] o_rgb;
   logic        o_hsync, o_vsync, o_de, o_sof;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int run    = 0;
   int mpat   = 0;
   int de_f1  = 0;
   int sof_cycles[$];

   logic [23:0] e_rgb;
   logic        e_hs, e_vs, e_de, e_sof;
   logic [23:0] bar_tab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   video_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(1'b1)
   ) dut (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .i_en     (i_en),
      .i_pattern(i_pattern),
      .o_rgb    (o_rgb),
      .o_hsync  (o_hsync),
      .o_vsync  (o_vsync),
      .o_de     (o_de),
      .o_sof    (o_sof)
   );

   always #5 pixelclk = ~pixelclk;

   function automatic logic [23:0] ref_pixel(input int pat, input int h, input int v);
      case (pat)
         0:       return bar_tab[h / (HA / 8)];
         1:       return {3{8'(h % 256)}};
         2:       return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
         default: return 24'h808080;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Expected outputs follow from the number of running cycles since the last restart
   task automatic model_edge();
      int pos, h, v;
      e_rgb = '0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0;
      if (!reset_n) begin
         run  = 0;
         mpat = 0;
      end else if (!i_en) begin
         run = 0;
      end else begin
         pos = run % FRAME;
         h   = pos % HT;
         v   = pos / HT;
         if (pos == 0) mpat = int'(i_pattern);
         e_de  = (h < HA) && (v < VA);
         e_hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
         e_vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
         e_sof = (pos == 0);
         e_rgb = e_de ? ref_pixel(mpat, h, v) : 24'h0;
         run++;
      end
   endtask

   task automatic tick();
      @(posedge pixelclk);
      model_edge();
      #1;
      cyc++;
      check("de",    32'(o_de),    32'(e_de));
      check("hsync", 32'(o_hsync), 32'(e_hs));
      check("vsync", 32'(o_vsync), 32'(e_vs));
      check("sof",   32'(o_sof),   32'(e_sof));
      check("rgb",   32'(o_rgb),   32'(e_rgb));
      if (!o_de) check("rgb_blank", 32'(o_rgb), 32'h0);
      if (o_sof) sof_cycles.push_back(cyc);
      if (o_de && cyc <= FRAME) de_f1++;
      @(negedge pixelclk);
   endtask

   initial begin
      // Reset state
      @(negedge pixelclk);
      repeat (3) tick();

      // Basic timing with bars, then switch to checkerboard mid-frame
      reset_n = 1'b1; i_en = 1'b1; i_pattern = 2'd0;
      cyc = 0; de_f1 = 0; sof_cycles.delete();
      while (cyc < 400) begin
         tick();
         if (cyc <= HT) begin
            check("line0_de", 32'(o_de), 32'(cyc >= 1 && cyc <= 16));
            check("line0_hs", 32'(o_hsync), 32'(cyc >= 19 && cyc <= 21));
         end
         if (cyc >= 121 && cyc <= 168) check("vs_lines5_6", 32'(o_vsync), 32'h1);
         if (cyc == 50) i_pattern = 2'd2;
      end
      check("de_per_frame", 32'(de_f1), 32'd64);
      check("sof_count", 32'(sof_cycles.size()), 32'd3);
      if (sof_cycles.size() == 3) begin
         check("sof0", 32'(sof_cycles[0]), 32'd1);
         check("sof1", 32'(sof_cycles[1]), 32'd193);
         check("sof2", 32'(sof_cycles[2]), 32'd385);
      end

      // Ramp and flat gray frames
      i_pattern = 2'd1;
      repeat (2 * FRAME) tick();
      i_pattern = 2'd3;
      repeat (2 * FRAME) tick();

      // Enable drop mid-frame and re-enable
      i_en = 1'b0; i_pattern = 2'd0;
      repeat (2) tick();
      i_en = 1'b1; cyc = 0;
      while (cyc < 200) begin
         tick();
         if (cyc > 70 && cyc <= 80) check("drop_idle", 32'(o_de | o_sof), 32'h0);
         if (cyc == 81) check("reen_sof", 32'({o_sof, o_de}), 32'h3);
         if (cyc == 70) i_en = 1'b0;
         if (cyc == 80) i_en = 1'b1;
      end

      // Reset mid-line with checkerboard latched
      i_pattern = 2'd2;
      repeat (FRAME + 30) tick();
      reset_n = 1'b0; i_pattern = 2'd0;
      tick();
      check("rst_rgb", 32'(o_rgb), 32'h0);
      check("rst_de", 32'({o_de, o_sof, o_hsync, o_vsync}), 32'h0);
      reset_n = 1'b1;
      repeat (FRAME + 10) tick();

      // Randomised inputs
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 999) >= 3);
         i_en    = ($urandom_range(0, 999) >= 5);
         if ($urandom_range(0, 39) == 0) i_pattern = 2'($urandom_range(0, 3));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
